// File: rtl/lif_layer_scheduler.sv
// lif_layer_scheduler: time-multiplexes one LIF core across the neurons of a
// fully connected layer. Each timestep it pulls NUM_INPUTS spike bits from the
// encoder, issues one INTEG op per neuron for every active input, then one
// LEAK_FIRE op per neuron, and collects the output spikes.
// Optional build macro LIF_SPIKE_COUNT_EN adds per-neuron spike counters and
// reports the winning neuron on the done pulse.
module lif_layer_scheduler #(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10,
  parameter int NUM_STEPS   = 16,
  parameter int PIX_W       = 10,
  parameter int NRN_W       = 4,
  parameter int STEP_W      = 5,
  parameter int WADDR_W     = 13
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_spike_valid,
  input  logic               in_spike,
  output logic               in_spike_ready,
  output logic               core_req,
  output logic [1:0]         core_op,
  input  logic               core_ack,
  input  logic               core_fire,
  output logic [NRN_W-1:0]   nrn_idx,
  output logic [WADDR_W-1:0] w_addr,
  output logic [PIX_W-1:0]   pix_idx,
  output logic [STEP_W-1:0]  step_idx,
  output logic               spike_out_valid,
  output logic [NRN_W-1:0]   spike_out_nrn,
  output logic               busy,
  output logic               done,
  output logic [NRN_W-1:0]   winner,
  output logic               winner_valid
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_INTEG, S_LEAK, S_DONE
  } state_t;

  localparam logic [1:0]         OP_INTEG  = 2'b00;
  localparam logic [1:0]         OP_LEAK   = 2'b01;
  localparam logic [1:0]         OP_CLEAR  = 2'b10;
  localparam logic [NRN_W-1:0]   NRN_LAST  = NRN_W'(NUM_NEURONS - 1);
  localparam logic [PIX_W-1:0]   PIX_LAST  = PIX_W'(NUM_INPUTS - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(NUM_STEPS - 1);
  localparam logic [WADDR_W-1:0] W_STRIDE  = WADDR_W'(NUM_NEURONS);

  state_t             state;
  logic [WADDR_W-1:0] w_base;
  logic               ack_ok;
  logic               nrn_last;
  logic               pix_last;
  logic [WADDR_W-1:0] base_next;

  // An ack only counts while a request is outstanding.
  assign ack_ok    = core_req & core_ack;
  assign nrn_last  = (nrn_idx == NRN_LAST);
  assign pix_last  = (pix_idx == PIX_LAST);
  // Running weight base: one row of NUM_NEURONS weights per pixel, wraps with pix.
  assign base_next = pix_last ? '0 : (w_base + W_STRIDE);

  assign in_spike_ready = (state == S_FETCH);

  // Scheduler FSM: sequencing, address counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      core_req        <= 1'b0;
      core_op         <= OP_INTEG;
      nrn_idx         <= '0;
      w_addr          <= '0;
      w_base          <= '0;
      pix_idx         <= '0;
      step_idx        <= '0;
      spike_out_valid <= 1'b0;
      spike_out_nrn   <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      spike_out_valid <= 1'b0;
      done            <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_CLEAR;
            core_req <= 1'b1;
            core_op  <= OP_CLEAR;
            nrn_idx  <= '0;
            pix_idx  <= '0;
            step_idx <= '0;
            w_base   <= '0;
            w_addr   <= '0;
            busy     <= 1'b1;
          end
        end

        S_CLEAR: begin
          if (ack_ok) begin
            if (nrn_last) begin
              nrn_idx  <= '0;
              core_req <= 1'b0;
              state    <= S_FETCH;
            end else begin
              nrn_idx <= nrn_idx + 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (in_spike_valid) begin
            if (in_spike) begin
              state    <= S_INTEG;
              core_req <= 1'b1;
              core_op  <= OP_INTEG;
              nrn_idx  <= '0;
            end else begin
              // Inactive pixel: no core work, just advance.
              w_base <= base_next;
              w_addr <= base_next;
              if (pix_last) begin
                pix_idx  <= '0;
                state    <= S_LEAK;
                core_req <= 1'b1;
                core_op  <= OP_LEAK;
              end else begin
                pix_idx <= pix_idx + 1'b1;
              end
            end
          end
        end

        S_INTEG: begin
          if (ack_ok) begin
            if (nrn_last) begin
              nrn_idx  <= '0;
              core_req <= 1'b0;
              w_base   <= base_next;
              w_addr   <= base_next;
              if (pix_last) begin
                pix_idx  <= '0;
                state    <= S_LEAK;
                core_req <= 1'b1;
                core_op  <= OP_LEAK;
              end else begin
                pix_idx <= pix_idx + 1'b1;
                state   <= S_FETCH;
              end
            end else begin
              nrn_idx <= nrn_idx + 1'b1;
              w_addr  <= w_addr + 1'b1;
            end
          end
        end

        S_LEAK: begin
          if (ack_ok) begin
            if (core_fire) begin
              spike_out_valid <= 1'b1;
              spike_out_nrn   <= nrn_idx;
            end
            if (nrn_last) begin
              nrn_idx  <= '0;
              core_req <= 1'b0;
              if (step_idx == STEP_LAST) begin
                step_idx <= '0;
                state    <= S_DONE;
                done     <= 1'b1;
                busy     <= 1'b0;
              end else begin
                step_idx <= step_idx + 1'b1;
                state    <= S_FETCH;
              end
            end else begin
              nrn_idx <= nrn_idx + 1'b1;
            end
          end
        end

        S_DONE: begin
          // start is deliberately not looked at here; a new image needs IDLE.
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [7:0]       spk_cnt [NUM_NEURONS];
  logic [7:0]       best_cnt;
  logic [NRN_W-1:0] best_idx;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

  // Per-neuron spike tally: cleared during CLEAR, bumped on every fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NEURONS; i++) spk_cnt[i] <= '0;
    end else if (state == S_CLEAR) begin
      for (int i = 0; i < NUM_NEURONS; i++) spk_cnt[i] <= '0;
    end else if (state == S_LEAK && ack_ok && core_fire) begin
      for (int i = 0; i < NUM_NEURONS; i++)
        if (nrn_idx == NRN_W'(i)) spk_cnt[i] <= sat_inc(spk_cnt[i]);
    end
  end

  // Arg-max over the counters; strict compare keeps the lowest index on ties.
  always_comb begin
    best_cnt = spk_cnt[0];
    best_idx = '0;
    for (int i = 1; i < NUM_NEURONS; i++) begin
      if (spk_cnt[i] > best_cnt) begin
        best_cnt = spk_cnt[i];
        best_idx = NRN_W'(i);
      end
    end
  end

  assign winner       = (state == S_DONE) ? best_idx : '0;
  assign winner_valid = (state == S_DONE);
`else
  assign winner       = '0;
  assign winner_valid = 1'b0;
`endif

endmodule

// File: tb/tb_lif_layer_scheduler.sv
// Scoreboard bench for lif_layer_scheduler (4 inputs, 2 neurons, 2 steps).
module tb_lif_layer_scheduler;
  localparam int NI = 4, NN = 2, NS = 2;
  localparam int PIX_W = 3, NRN_W = 2, STEP_W = 2, WADDR_W = 4;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic in_spike_valid = 1'b0, in_spike = 1'b0;
  logic core_ack = 1'b0, core_fire = 1'b0;
  logic               in_spike_ready, core_req, spike_out_valid, busy, done, winner_valid;
  logic [1:0]         core_op;
  logic [NRN_W-1:0]   nrn_idx, spike_out_nrn, winner;
  logic [WADDR_W-1:0] w_addr;
  logic [PIX_W-1:0]   pix_idx;
  logic [STEP_W-1:0]  step_idx;

  lif_layer_scheduler #(
    .NUM_INPUTS(NI), .NUM_NEURONS(NN), .NUM_STEPS(NS),
    .PIX_W(PIX_W), .NRN_W(NRN_W), .STEP_W(STEP_W), .WADDR_W(WADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_spike_valid(in_spike_valid), .in_spike(in_spike), .in_spike_ready(in_spike_ready),
    .core_req(core_req), .core_op(core_op), .core_ack(core_ack), .core_fire(core_fire),
    .nrn_idx(nrn_idx), .w_addr(w_addr), .pix_idx(pix_idx), .step_idx(step_idx),
    .spike_out_valid(spike_out_valid), .spike_out_nrn(spike_out_nrn),
    .busy(busy), .done(done), .winner(winner), .winner_valid(winner_valid)
  );

  always #5 clk = ~clk;

  typedef struct {int op; int nrn; int waddr; int pix; int step;} op_t;

  op_t op_q[$];
  int  spk_q[$];
  int  done_q[$];
  int  enc_q[$];
  int  total = 0, bad = 0;
  bit  img_spk [NS][NI];
  bit  img_fire[NS][NN];
  bit  fire_tbl[NS][NN];
  int  leak_k = 0, dly_lo = 0, dly_hi = 0, stall_mode = 0, gen = 0, done_seen = 0;
  op_t m_e;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: lists every core op, output spike and the winner.
  task automatic build_model();
    int cnt[NN];
    int best;
    for (int n = 0; n < NN; n++) begin
      cnt[n] = 0;
      op_q.push_back('{2, n, 0, 0, 0});
    end
    for (int s = 0; s < NS; s++) begin
      for (int p = 0; p < NI; p++) begin
        enc_q.push_back(int'(img_spk[s][p]));
        if (img_spk[s][p])
          for (int n = 0; n < NN; n++) op_q.push_back('{0, n, p * NN + n, p, s});
      end
      for (int n = 0; n < NN; n++) begin
        op_q.push_back('{1, n, 0, 0, s});
        if (img_fire[s][n]) begin
          spk_q.push_back(n);
          cnt[n]++;
        end
      end
    end
    best = 0;
    for (int n = 1; n < NN; n++) if (cnt[n] > cnt[best]) best = n;
    done_q.push_back(best);
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < NN; n++) fire_tbl[s][n] = img_fire[s][n];
    leak_k = 0;
  endtask

  task automatic run_image(input int poke);
    int guard;
    build_model();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", int'(busy), 1);
    if (poke != 0) begin
      repeat (6) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    guard = 0;
    while (guard < 20000) begin
      @(negedge clk);
      #2;
      if (done) break;
      guard++;
    end
    if (guard >= 20000) chk("done_timeout", 1, 0);
    start = 1'b1;   // coincides with done: must be ignored
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_on_done_busy", int'(busy), 0);
    chk("start_on_done_req", int'(core_req), 0);
    chk("ops_left", op_q.size(), 0);
    chk("spikes_left", spk_q.size(), 0);
    chk("done_left", done_q.size(), 0);
    chk("enc_left", enc_q.size(), 0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an op, spike or done.
  initial forever begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (core_req && core_ack) begin
        if (op_q.size() == 0) chk("op_unexpected", int'(core_op), -1);
        else begin
          m_e = op_q.pop_front();
          chk("core_op", int'(core_op), m_e.op);
          chk("nrn_idx", int'(nrn_idx), m_e.nrn);
          chk("w_addr", int'(w_addr), m_e.waddr);
          chk("pix_idx", int'(pix_idx), m_e.pix);
          chk("step_idx", int'(step_idx), m_e.step);
        end
      end
      if (spike_out_valid) begin
        if (spk_q.size() == 0) chk("spike_unexpected", int'(spike_out_nrn), -1);
        else chk("spike_out_nrn", int'(spike_out_nrn), spk_q.pop_front());
      end
      if (done) begin
        done_seen++;
        chk("busy_at_done", int'(busy), 0);
        if (done_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
`ifdef LIF_SPIKE_COUNT_EN
          chk("winner", int'(winner), done_q.pop_front());
          chk("winner_valid", int'(winner_valid), 1);
`else
          void'(done_q.pop_front());
          chk("winner_off", int'(winner), 0);
          chk("winner_valid_off", int'(winner_valid), 0);
`endif
        end
      end
    end
  end

  // Core model: acks each request after a programmable delay, checks hold.
  initial begin
    int cnt;
    int s_op, s_nrn, s_w;
    cnt = -1; s_op = 0; s_nrn = 0; s_w = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        core_ack = 1'b0; core_fire = 1'b0; cnt = -1;
      end else begin
        if (core_ack) begin
          core_ack = 1'b0; core_fire = 1'b0; cnt = -1;
        end
        if (core_req) begin
          if (cnt < 0) begin
            cnt = int'($urandom_range(dly_hi, dly_lo));
            s_op = int'(core_op); s_nrn = int'(nrn_idx); s_w = int'(w_addr);
          end else begin
            chk("hold_op", int'(core_op), s_op);
            chk("hold_nrn", int'(nrn_idx), s_nrn);
            chk("hold_waddr", int'(w_addr), s_w);
          end
          if (cnt == 0) begin
            core_ack = 1'b1;
            if (core_op == 2'b01 && leak_k < NS * NN) begin
              core_fire = fire_tbl[leak_k / NN][leak_k % NN];
              leak_k++;
            end
          end else cnt--;
        end
      end
    end
  end

  // Encoder model: presents queued spike bits with idle gaps, holds until taken.
  initial begin
    int g, b, gap, guard;
    forever begin
      @(negedge clk);
      if (enc_q.size() > 0 && !rst) begin
        g = gen;
        b = enc_q.pop_front();
        gap = (stall_mode != 0) ? 5 : int'($urandom_range(2, 0));
        repeat (gap) @(negedge clk);
        if (g == gen) begin
          in_spike_valid = 1'b1;
          in_spike = b[0];
          guard = 0;
          while (!in_spike_ready && guard < 5000 && g == gen) begin
            @(negedge clk);
            guard++;
          end
          if (guard >= 5000) chk("enc_timeout", 1, 0);
          if (g == gen) @(negedge clk);
          in_spike_valid = 1'b0;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, d0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_core_req", int'(core_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(in_spike_ready), 0);
    chk("rst_nrn", int'(nrn_idx), 0);
    chk("rst_waddr", int'(w_addr), 0);
    chk("rst_step", int'(step_idx), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;
    @(negedge clk);

    // Sparse 1,0,0,1 pattern, no fires, minimum ack latency.
    for (int s = 0; s < NS; s++) begin
      for (int p = 0; p < NI; p++) img_spk[s][p] = (p == 0 || p == 3);
      for (int n = 0; n < NN; n++) img_fire[s][n] = 1'b0;
    end
    dly_lo = 0; dly_hi = 0; stall_mode = 0;
    run_image(0);

    // Neuron 1 fires in both steps, under encoder stalls and slow acks.
    for (int s = 0; s < NS; s++) begin
      for (int p = 0; p < NI; p++) img_spk[s][p] = bit'($urandom_range(1, 0));
      img_spk[s][1] = 1'b1;
      img_fire[s][0] = 1'b0;
      img_fire[s][1] = 1'b1;
    end
    dly_lo = 4; dly_hi = 4; stall_mode = 1;
    run_image(0);

    // Random images with random ack delays; one gets a start while busy.
    stall_mode = 0; dly_lo = 0; dly_hi = 3;
    for (int k = 0; k < 3; k++) begin
      for (int s = 0; s < NS; s++) begin
        for (int p = 0; p < NI; p++) img_spk[s][p] = bit'($urandom_range(1, 0));
        for (int n = 0; n < NN; n++) img_fire[s][n] = bit'($urandom_range(1, 0));
      end
      run_image(k == 0 ? 1 : 0);
    end

    // Abort mid-INTEG: everything clears at once and no done follows.
    for (int s = 0; s < NS; s++) begin
      for (int p = 0; p < NI; p++) img_spk[s][p] = 1'b1;
      for (int n = 0; n < NN; n++) img_fire[s][n] = 1'b0;
    end
    build_model();
    d0 = done_seen;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(core_req && core_op == 2'b00) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) chk("abort_wait_integ", 1, 0);
    rst = 1'b1;
    gen++;
    #1;
    chk("abort_core_req", int'(core_req), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_nrn", int'(nrn_idx), 0);
    chk("abort_waddr", int'(w_addr), 0);
    chk("abort_pix", int'(pix_idx), 0);
    chk("abort_ready", int'(in_spike_ready), 0);
    op_q.delete(); spk_q.delete(); done_q.delete(); enc_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_done", done_seen, d0);
    chk("abort_idle_busy", int'(busy), 0);

    // Fresh image after the abort.
    for (int s = 0; s < NS; s++) begin
      for (int p = 0; p < NI; p++) img_spk[s][p] = bit'($urandom_range(1, 0));
      for (int n = 0; n < NN; n++) img_fire[s][n] = bit'($urandom_range(1, 0));
    end
    run_image(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lif_layer_scheduler.md
Name: lif_layer_scheduler

Overview:
- Time-multiplexes one shared LIF neuron core across NUM_NEURONS neurons of a fully connected layer.
- For each image it runs NUM_STEPS timesteps. Each timestep consumes NUM_INPUTS input spikes from the spike encoder, issues one integrate op per neuron for every active input, then one leak+fire op per neuron.
- Generates weight and membrane addresses, collects output spikes, and sits between the spike encoder and the LIF core/weight ROM.

Parameters:
- NUM_INPUTS, 784, input pixels per timestep
- NUM_NEURONS, 10, neurons sharing the core
- NUM_STEPS, 16, timesteps per image
- PIX_W, 10, pixel index width (>= clog2(NUM_INPUTS))
- NRN_W, 4, neuron index width (>= clog2(NUM_NEURONS))
- STEP_W, 5, timestep index width (>= clog2(NUM_STEPS+1))
- WADDR_W, 13, weight address width (>= clog2(NUM_INPUTS*NUM_NEURONS))

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse, begin an image; ignored when busy=1
- in_spike_valid  in  1  encoder spike bit valid
- in_spike  in  1  spike bit for current pixel
- in_spike_ready  out  1  scheduler accepts spike bit
- core_req  out  1  op request to LIF core
- core_op  out  2  00=INTEG, 01=LEAK_FIRE, 10=CLEAR
- core_ack  in  1  one-cycle op completion
- core_fire  in  1  neuron fired; sampled only with core_ack during LEAK_FIRE
- nrn_idx  out  NRN_W  neuron (membrane RAM address) for current op
- w_addr  out  WADDR_W  pix_idx*NUM_NEURONS+nrn_idx, valid with core_req for INTEG
- pix_idx  out  PIX_W  current pixel
- step_idx  out  STEP_W  current timestep
- spike_out_valid  out  1  one-cycle pulse per output spike
- spike_out_nrn  out  NRN_W  neuron that fired
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse, image complete
- winner  out  NRN_W  see Optional Feature
- winner_valid  out  1  see Optional Feature

Behaviour:
- Reset (async): state=IDLE. All outputs 0, all counters 0. Reset mid-operation abandons the image silently; no done pulse.
- IDLE: start=1 -> CLEAR with nrn=0, pix=0, step=0. busy rises the next cycle.
- CLEAR: core_req=1, core_op=10 for each neuron 0..NUM_NEURONS-1, in order. Then -> FETCH.
- FETCH: in_spike_ready=1. Handshake completes on the cycle in_spike_valid & in_spike_ready.
  - Spike=1 -> INTEG with nrn=0.
  - Spike=0 -> skip. pix increments; if pix was NUM_INPUTS-1 -> LEAK with nrn=0, pix wraps to 0.
- INTEG: core_req=1, core_op=00 for each neuron in turn. After the ack for neuron NUM_NEURONS-1, apply the same pixel advance/wrap rule as FETCH; otherwise -> FETCH.
- LEAK: core_req=1, core_op=01 for each neuron. On ack with core_fire=1, spike_out_valid pulses the next cycle with spike_out_nrn=that neuron. After the last neuron's ack:
  - step increments.
  - If step was NUM_STEPS-1 -> DONE; else -> FETCH.
- DONE: done=1 for one cycle, busy=0 the same cycle -> IDLE.
- Core handshake:
  - core_req rises registered on state entry and holds until core_ack.
  - The ack cycle advances nrn_idx. core_req stays high if another op of the same type follows; otherwise it drops the next cycle.
  - core_ack arriving while core_req=0 is ignored.
  - Minimum op latency: 1 cycle (ack in the cycle after req rises).
- nrn_idx, w_addr and core_op are stable for the entire core_req high interval.
- w_addr is computed with a running adder: +1 per neuron, base advances by NUM_NEURONS per pixel. No multiplier. Wraps to 0 at pixel wrap.
- Counter wrap: nrn wraps at NUM_NEURONS-1, pix at NUM_INPUTS-1, step at NUM_STEPS-1. No out-of-range values are ever driven.
- in_spike_ready=0 outside FETCH; encoder must hold valid/data.
- start during busy: ignored, no state change.
- start coincident with done: ignored; a new image needs start while IDLE.

Optional Feature:
- Macro: LIF_SPIKE_COUNT_EN.
- Defined:
  - Per-neuron saturating 8-bit spike counters, cleared in CLEAR, incremented on each fire.
  - At DONE, winner = lowest-index neuron with maximum count, winner_valid=1 for the done cycle.
  - All counts zero -> winner=0, winner_valid=1.
- Undefined: no counters; winner=0 and winner_valid=0 constantly.

Test Plan:
- Test configuration: NUM_INPUTS=4, NUM_NEURONS=2, NUM_STEPS=2, core acks 1 cycle after req.
- Reset/start: hold rst 3 cycles, pulse start -> exactly 2 CLEAR ops (nrn 0,1); busy=1 until done.
- Sparse input: spikes 1,0,0,1 in each step, core_fire=0 -> INTEG w_addr sequence 0,1,6,7 per step; 4 LEAK ops total; done one cycle after last LEAK ack; no spike_out_valid.
- Fire collection: step 0 LEAK returns fire=1 for nrn 1 -> spike_out_valid pulse with spike_out_nrn=1; with LIF_SPIKE_COUNT_EN, step 1 fire on nrn 1 -> winner=1, winner_valid=1 on done.
- Backpressure/stall: in_spike_valid low 5 cycles in FETCH, core_ack delayed 4 cycles -> core_req, nrn_idx, w_addr held stable; no ops skipped or duplicated.
- Abort/ignore: start pulsed while busy -> ignored; rst asserted mid-INTEG -> all outputs 0 immediately, no done; a fresh start runs a full image correctly.
